// File: rtl/width_down_fifo.sv
// rtl/width_down_fifo.sv - word FIFO feeding a wide-to-narrow slice serializer
module width_down_fifo #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [IN_W-1:0]              in_data,
  output logic                         in_ready,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         empty
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [IN_W-1:0] mem [DEPTH];

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0] word_q, word_d;

  logic full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic accept;
  logic at_last;

  assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign in_ready   = !full;

  assign at_last = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
  assign accept  = (state_q == ST_SHIFT) && out_ready;
  assign push    = reset_n && !flush && in_valid && !full;
  // A load happens from IDLE, or on the final slice so the next word follows without a bubble.
  assign pop     = !flush && !fifo_empty && ((state_q == ST_IDLE) || (accept && at_last));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (accept) begin
      if (at_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        word_d = (MSB_FIRST != 0) ? (word_q << OUT_W) : (word_q >> OUT_W);
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      state_d  = ST_SHIFT;
      cnt_d    = '0;
      word_d   = mem[rd_ptr_q[AW-1:0]];
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = ST_IDLE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= wr_ptr_d - rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // The held word is never reset; every output that exposes it is gated by state.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  assign out_valid = (state_q == ST_SHIFT);
  assign out_last  = at_last;
  assign out_data  = (state_q != ST_SHIFT) ? '0 :
                     (MSB_FIRST != 0) ? word_q[IN_W-1 -: OUT_W] : word_q[OUT_W-1:0];
  assign level     = level_q;
  assign empty     = (level_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_width_down_fifo.sv
// tb/tb_width_down_fifo.sv - randomized scoreboard bench for width_down_fifo
module tb_width_down_fifo;

  localparam int IN_W  = 64;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;

  logic              clk = 1'b0;
  logic              reset_n, flush;
  logic              in_valid, in_ready, out_ready, out_valid, out_last, empty;
  logic [IN_W-1:0]   in_data;
  logic [OUT_W-1:0]  out_data;
  logic [3:0]        level;

  logic              in_valid_l, in_ready_l, out_ready_l, out_valid_l, out_last_l, empty_l;
  logic [IN_W-1:0]   in_data_l;
  logic [OUT_W-1:0]  out_data_l;
  logic [3:0]        level_l;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;

  logic [OUT_W:0]   exp_q[$];
  bit               stall_q = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic             held_last;

  width_down_fifo dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .level(level), .empty(empty)
  );

  width_down_fifo #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid_l), .in_data(in_data_l), .in_ready(in_ready_l),
    .out_ready(out_ready_l), .out_valid(out_valid_l), .out_data(out_data_l),
    .out_last(out_last_l), .level(level_l), .empty(empty_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: each accepted word becomes RATIO slices, MSB slice first; flush/reset discard all.
  always @(negedge clk) begin
    if (!reset_n || flush) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_slice: got 0x%0h expected no slice at %0t", out_data, $time);
        end else begin
          logic [OUT_W:0] e;
          e = exp_q.pop_front();
          check("slice_data", out_data, e[OUT_W-1:0]);
          check("slice_last", out_last, e[OUT_W]);
        end
        pops++;
      end
      stall_q   = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (in_valid && in_ready) begin
        for (int j = 0; j < RATIO; j++) begin
          logic [IN_W-1:0] w;
          w = in_data >> ((RATIO - 1 - j) * OUT_W);
          exp_q.push_back({(j == RATIO - 1), w[OUT_W-1:0]});
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, (n < 300), 1);
    @(negedge clk);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic abort_test(input bit use_reset);
    int p0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = rand64();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("abort_pre_level", level, 4);
    check("abort_pre_valid", out_valid, 1);
    tick();
    if (use_reset) reset_n = 1'b0;
    else flush = 1'b1;
    in_valid = 1'b1;
    in_data  = rand64();
    tick();
    reset_n  = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check(use_reset ? "rst_valid" : "flush_valid", out_valid, 0);
    check(use_reset ? "rst_level" : "flush_level", level, 0);
    check(use_reset ? "rst_empty" : "flush_empty", empty, 1);
    p0 = pops;
    tick();
    in_valid = 1'b1;
    in_data  = rand64();
    tick();
    drain(use_reset ? "rst_new" : "flush_new");
    check(use_reset ? "rst_new_slices" : "flush_new_slices", pops - p0, RATIO);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [IN_W-1:0] w;
    int run;
    int n;
    reset_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid_l = 1'b0; in_data_l = '0; out_ready_l = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);

    // Known word into both orderings, with the two-cycle first-slice latency.
    w = 64'h0123456789ABCDEF;
    tick();
    in_valid = 1'b1; in_data = w;
    in_valid_l = 1'b1; in_data_l = w;
    tick();
    in_valid = 1'b0; in_valid_l = 1'b0;
    @(negedge clk);
    check("lat_not_yet", out_valid, 0);
    tick();
    for (int i = 0; i < RATIO; i++) begin
      logic [IN_W-1:0] s;
      @(negedge clk);
      s = w >> (i * OUT_W);
      check("msb_valid", out_valid, 1);
      check("msb_last", out_last, (i == RATIO - 1));
      check("lsb_data", out_data_l, s[OUT_W-1:0]);
      check("lsb_last", out_last_l, (i == RATIO - 1));
    end
    @(negedge clk);
    check("word_done_valid", out_valid, 0);
    check("word_done_empty", empty, 1);

    // Fill: one word in the serializer plus eight stored, tenth write refused.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = rand64();
      if (i == 9) begin
        @(negedge clk);
        check("full_level", level, 8);
        check("full_in_ready", in_ready, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_level_hold", level, 8);
    tick();
    drain("full_drain");

    // Two back-to-back words must stream with no gap at the boundary.
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = rand64();
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    run = out_valid ? 1 : 0;
    for (int i = 1; i < 2 * RATIO; i++) begin
      @(negedge clk);
      if (out_valid) run++;
    end
    check("b2b_run", run, 2 * RATIO);
    @(negedge clk);
    check("b2b_after", out_valid, 0);
    tick();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rand64();
      out_ready = ($urandom_range(0, 3) != 0) && (i % 50 < 40);
      tick();
    end
    drain("rand_drain");
    tick();

    abort_test(1'b0);
    tick();
    abort_test(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
